// File: rtl/acl_frame_sequencer.sv
// acl_frame_sequencer
//
// Controls the read side of the ingress frame FIFO. It counts the words of each
// received frame and waits for the ACL verdict on that frame. On a permit it drains
// the frame to the egress AXI-Stream. On a deny or a verdict timeout it reads the
// frame out of the FIFO and discards it. Only one frame is in flight at a time.
// While a frame is pending, o_rx_hold stops upstream from presenting more words.
//
// Parameters
//   CNT_W        width of the FIFO word count and frame length (max frame 2**CNT_W-1)
//   TIMEOUT_CYC  cycles to wait in WAIT_ACL before a forced drop (>= 2)
//   STAT_W       width of the statistics counters (only with ACL_SEQ_STATS_EN)
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   i_rxd_tvalid/tready/tlast  ingress handshake as seen by the FIFO write side
//   i_wr_cnt          FIFO occupancy
//   i_acl_valid/permit one-cycle verdict strobe and verdict value
//   i_txd_tready      egress sink ready
//   o_rx_hold         upstream must stop presenting words while a frame is pending
//   o_rd_valid        FIFO read strobe, one word per high cycle
//   o_fifo_invalid    qualifies reads as discards (high while dropping)
//   o_txd_tvalid/tlast egress word valid / last, aligned with the FIFO read data
//   o_len_err         sticky, set when a frame exceeded 2**CNT_W-1 words
//   o_fwd_cnt/o_drop_cnt/o_tmo_cnt  frame statistics (only with ACL_SEQ_STATS_EN)
//
// Build option
//   ACL_SEQ_STATS_EN  define to add the three statistics counters and their ports.

module acl_frame_sequencer #(
    parameter int CNT_W       = 9,
    parameter int TIMEOUT_CYC = 1024
`ifdef ACL_SEQ_STATS_EN
    ,
    parameter int STAT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rxd_tvalid,
    input  logic              i_rxd_tready,
    input  logic              i_rxd_tlast,
    input  logic [CNT_W-1:0]  i_wr_cnt,
    input  logic              i_acl_valid,
    input  logic              i_acl_permit,
    input  logic              i_txd_tready,
    output logic              o_rx_hold,
    output logic              o_rd_valid,
    output logic              o_fifo_invalid,
    output logic              o_txd_tvalid,
    output logic              o_txd_tlast,
`ifdef ACL_SEQ_STATS_EN
    output logic [STAT_W-1:0] o_fwd_cnt,
    output logic [STAT_W-1:0] o_drop_cnt,
    output logic [STAT_W-1:0] o_tmo_cnt,
`endif
    output logic              o_len_err
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACL,
        FORWARD,
        DROP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               pending_q, pending_d;
    logic               frame_ovf_q, frame_ovf_d;
    logic               frame_err_q, frame_err_d;
    logic               len_err_q, len_err_d;
    logic               txd_tvalid_q, txd_tvalid_d;
    logic               txd_tlast_q, txd_tlast_d;
    logic               rd_valid;
    logic               fifo_invalid;
    logic               rx_accept;

    // Words offered while a frame is pending are not counted.
    assign rx_accept = i_rxd_tvalid & i_rxd_tready & ~pending_q;

    // Next-state logic: the ingress word counter, then the verdict/drain FSM.
    // frame_ovf tracks words that arrived after the counter saturated. frame_err
    // marks the pending frame as oversize, which forces a drop whatever the verdict.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        len_d        = len_q;
        rem_d        = rem_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        frame_ovf_d  = frame_ovf_q;
        frame_err_d  = frame_err_q;
        len_err_d    = len_err_q;
        txd_tvalid_d = 1'b0;
        txd_tlast_d  = 1'b0;
        rd_valid     = 1'b0;
        fifo_invalid = 1'b0;

        if (rx_accept) begin
            if (i_rxd_tlast) begin
                len_d       = (wcnt_q == CNT_MAX) ? CNT_MAX : wcnt_q + CNT_W'(1);
                frame_err_d = frame_ovf_q | (wcnt_q == CNT_MAX);
                if (frame_ovf_q | (wcnt_q == CNT_MAX)) begin
                    len_err_d = 1'b1;
                end
                wcnt_d      = '0;
                frame_ovf_d = 1'b0;
                pending_d   = 1'b1;
            end else if (wcnt_q == CNT_MAX) begin
                frame_ovf_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d = WAIT_ACL;
                    timer_d = '0;
                end
            end
            WAIT_ACL: begin
                timer_d = timer_q + TMR_W'(1);
                // A verdict that arrives in the same cycle as the timeout takes priority.
                if (i_acl_valid) begin
                    state_d = (i_acl_permit & ~frame_err_q) ? FORWARD : DROP;
                    rem_d   = len_q;
                end else if (timer_q == TMR_LAST) begin
                    state_d = DROP;
                    rem_d   = len_q;
                end
            end
            FORWARD: begin
                if (rem_q == '0) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else begin
                    rd_valid = i_txd_tready & (i_wr_cnt != '0);
                    if (rd_valid) begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
                // The FIFO has one cycle of read latency, so egress valid trails the read.
                txd_tvalid_d = rd_valid;
                txd_tlast_d  = rd_valid & (rem_q == CNT_W'(1));
            end
            DROP: begin
                fifo_invalid = 1'b1;
                if (rem_q == '0) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else begin
                    rd_valid = (i_wr_cnt != '0);
                    if (rd_valid) begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. A reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            frame_ovf_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            len_err_q    <= 1'b0;
            txd_tvalid_q <= 1'b0;
            txd_tlast_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            frame_ovf_q  <= frame_ovf_d;
            frame_err_q  <= frame_err_d;
            len_err_q    <= len_err_d;
            txd_tvalid_q <= txd_tvalid_d;
            txd_tlast_q  <= txd_tlast_d;
        end
    end

    assign o_rx_hold      = pending_q;
    assign o_rd_valid     = rd_valid;
    assign o_fifo_invalid = fifo_invalid;
    assign o_txd_tvalid   = txd_tvalid_q;
    assign o_txd_tlast    = txd_tlast_q;
    assign o_len_err      = len_err_q;

`ifdef ACL_SEQ_STATS_EN
    logic [STAT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [STAT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Frame statistics. Each counter counts entries into FORWARD or DROP. A drop
    // with no verdict strobe in that cycle was caused by the timeout.
    always_comb begin
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        if (state_q == WAIT_ACL && state_d == FORWARD) begin
            fwd_cnt_d = fwd_cnt_q + STAT_W'(1);
        end
        if (state_q == WAIT_ACL && state_d == DROP) begin
            drop_cnt_d = drop_cnt_q + STAT_W'(1);
            if (!i_acl_valid) begin
                tmo_cnt_d = tmo_cnt_q + STAT_W'(1);
            end
        end
    end

    // Statistics registers, cleared only by reset and wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign o_fwd_cnt  = fwd_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_tmo_cnt  = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_acl_frame_sequencer.sv
// tb_acl_frame_sequencer
//
// Directed bench for acl_frame_sequencer. Each frame the stimulus sends pushes its
// expected FIFO reads (drop or forward, data word, last flag) onto a queue. A
// negedge monitor pops one entry per o_rd_valid and checks the read qualifier and
// the FIFO data order. It also checks that egress valid/last appear one cycle after
// each forwarded read. A small FIFO model supplies i_wr_cnt.

module tb_acl_frame_sequencer;

    localparam int CNT_W = 9;
    localparam int TMO   = 64;
    localparam int MAXW  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        drop;
        logic        last;
        logic [15:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_rxd_tvalid;
    logic             i_rxd_tready;
    logic             i_rxd_tlast;
    logic [CNT_W-1:0] i_wr_cnt;
    logic             i_acl_valid;
    logic             i_acl_permit;
    logic             i_txd_tready;
    logic             o_rx_hold;
    logic             o_rd_valid;
    logic             o_fifo_invalid;
    logic             o_txd_tvalid;
    logic             o_txd_tlast;
    logic             o_len_err;
`ifdef ACL_SEQ_STATS_EN
    logic [15:0]      o_fwd_cnt;
    logic [15:0]      o_drop_cnt;
    logic [15:0]      o_tmo_cnt;
`endif

    int          vectors = 0;
    int          fails   = 0;
    exp_t        exp_q[$];
    logic [15:0] fifo_q[$];
    int          data_next = 0;
    logic        stall     = 1'b0;
    logic        toggle_en = 1'b0;
    logic        pend_v    = 1'b0;
    logic        pend_last = 1'b0;
    logic        tready_prev = 1'b0;
    int          cyc = 0;
    int          tv_cnt = 0;
    int          tv_first = -1;
    int          tv_last = -1;
    exp_t        mon_e;
    logic [15:0] mon_d;

    acl_frame_sequencer #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rxd_tvalid   (i_rxd_tvalid),
        .i_rxd_tready   (i_rxd_tready),
        .i_rxd_tlast    (i_rxd_tlast),
        .i_wr_cnt       (i_wr_cnt),
        .i_acl_valid    (i_acl_valid),
        .i_acl_permit   (i_acl_permit),
        .i_txd_tready   (i_txd_tready),
        .o_rx_hold      (o_rx_hold),
        .o_rd_valid     (o_rd_valid),
        .o_fifo_invalid (o_fifo_invalid),
        .o_txd_tvalid   (o_txd_tvalid),
        .o_txd_tlast    (o_txd_tlast),
`ifdef ACL_SEQ_STATS_EN
        .o_fwd_cnt      (o_fwd_cnt),
        .o_drop_cnt     (o_drop_cnt),
        .o_tmo_cnt      (o_tmo_cnt),
`endif
        .o_len_err      (o_len_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // The FIFO occupancy follows the model after each edge. It can be forced to zero to stall reads.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall) i_wr_cnt = '0;
            else if (fifo_q.size() > MAXW) i_wr_cnt = CNT_W'(MAXW);
            else i_wr_cnt = CNT_W'(fifo_q.size());
        end
    end

    // The egress sink toggles its ready every cycle when toggling is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) i_txd_tready = ~i_txd_tready;
        end
    end

    // Scoreboard monitor: checks egress against the previous cycle's forwarded read and pops one expectation per read.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend_v      = 1'b0;
            tready_prev = 1'b0;
        end else begin
            checkOutput("txd_tvalid", int'(o_txd_tvalid), int'(pend_v));
            checkOutput("txd_tlast", int'(o_txd_tlast), int'(pend_v & pend_last));
            if (o_txd_tvalid) begin
                checkOutput("tready_before_tvalid", int'(tready_prev), 1);
                tv_cnt++;
                if (tv_first < 0) tv_first = cyc;
                tv_last = cyc;
            end
            pend_v = 1'b0;
            if (o_rd_valid) begin
                checkOutput("rd_wr_cnt_nonzero", int'(i_wr_cnt != '0), 1);
                vectors++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL read_expected: got a FIFO read, expected none (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("fifo_invalid", int'(o_fifo_invalid), int'(mon_e.drop));
                    mon_d = (fifo_q.size() > 0) ? fifo_q.pop_front() : 16'hFFFF;
                    checkOutput("read_data", int'(mon_d), int'(mon_e.data));
                    if (!mon_e.drop) begin
                        pend_v    = 1'b1;
                        pend_last = mon_e.last;
                    end
                end
            end
            tready_prev = i_txd_tready;
        end
    end

    // Sends one frame and queues its expected reads. verdict: 0 deny, 1 permit, 2 none.
    // delay is the number of cycles from tlast to the verdict strobe (>= 1).
    task automatic applyStimulus(input int words, input int verdict, input int delay);
        int   nexp;
        int   c;
        logic drop;
        exp_t e;
        nexp = (words > MAXW) ? MAXW : words;
        drop = (verdict != 1) || (words > MAXW);
        c = 0;
        while (o_rx_hold && c < 4000) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("rx_hold_before_frame", int'(o_rx_hold), 0);
        for (int i = 0; i < nexp; i++) begin
            e.drop = drop;
            e.last = (i == nexp - 1);
            e.data = 16'(data_next + i);
            exp_q.push_back(e);
        end
        for (int i = 0; i < words; i++) begin
            i_rxd_tvalid = 1'b1;
            i_rxd_tlast  = (i == words - 1);
            @(posedge clk);
            fifo_q.push_back(16'(data_next));
            data_next++;
            #1;
        end
        i_rxd_tvalid = 1'b0;
        i_rxd_tlast  = 1'b0;
        checkOutput("rx_hold_after_tlast", int'(o_rx_hold), 1);
        if (verdict != 2) begin
            repeat (delay) @(posedge clk);
            #1;
            i_acl_valid  = 1'b1;
            i_acl_permit = (verdict == 1);
            @(posedge clk);
            #1;
            i_acl_valid  = 1'b0;
            i_acl_permit = 1'b0;
        end
    endtask

    // Waits, with a bound, until all expected reads are done and the hold is released.
    task automatic waitDone(input string name, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || o_rx_hold) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput({name, "_reads_left"}, exp_q.size(), 0);
        checkOutput({name, "_rx_hold_released"}, int'(o_rx_hold), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        i_rxd_tvalid = 1'b0;
        i_rxd_tready = 1'b1;
        i_rxd_tlast  = 1'b0;
        i_wr_cnt     = '0;
        i_acl_valid  = 1'b0;
        i_acl_permit = 1'b0;
        i_txd_tready = 1'b1;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rx_hold", int'(o_rx_hold), 0);
        checkOutput("reset_rd_valid", int'(o_rd_valid), 0);
        checkOutput("reset_fifo_invalid", int'(o_fifo_invalid), 0);
        checkOutput("reset_txd_tvalid", int'(o_txd_tvalid), 0);
        checkOutput("reset_txd_tlast", int'(o_txd_tlast), 0);
        checkOutput("reset_len_err", int'(o_len_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] 16-word frame, permit 3 cycles after tlast");
        tv_cnt = 0; tv_first = -1; tv_last = -1;
        applyStimulus(16, 1, 3);
        waitDone("permit16", 200);
        checkOutput("permit16_tvalid_count", tv_cnt, 16);
        checkOutput("permit16_contiguous_span", tv_last - tv_first + 1, 16);

        $display("[TB] 16-word frame, deny");
        tv_cnt = 0;
        applyStimulus(16, 0, 2);
        waitDone("deny16", 200);
        checkOutput("deny16_tvalid_count", tv_cnt, 0);

        $display("[TB] 4-word frame, no verdict");
        applyStimulus(4, 2, 0);
        c = 0;
        while (!o_fifo_invalid && c < TMO + 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        // Hold rises at the tlast edge, WAIT_ACL starts one edge later and lasts TMO cycles.
        checkOutput("timeout_edges_to_drop", c, TMO + 1);
        waitDone("timeout", TMO + 100);
`ifdef ACL_SEQ_STATS_EN
        checkOutput("stats_fwd_cnt", int'(o_fwd_cnt), 1);
        checkOutput("stats_drop_cnt", int'(o_drop_cnt), 2);
        checkOutput("stats_tmo_cnt", int'(o_tmo_cnt), 1);
`endif

        $display("[TB] 10-word frame, permit, toggling egress ready");
        tv_cnt = 0;
        toggle_en = 1'b1;
        applyStimulus(10, 1, 1);
        waitDone("toggle10", 200);
        toggle_en = 1'b0;
        i_txd_tready = 1'b1;
        checkOutput("toggle10_tvalid_count", tv_cnt, 10);

        $display("[TB] 8-word frame, permit, FIFO count held at zero");
        tv_cnt = 0;
        stall = 1'b1;
        applyStimulus(8, 1, 1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("stall_tvalid_count", tv_cnt, 0);
        stall = 1'b0;
        waitDone("stall8", 200);
        checkOutput("stall8_tvalid_count", tv_cnt, 8);

        $display("[TB] 1-word frame, permit");
        tv_cnt = 0;
        applyStimulus(1, 1, 1);
        waitDone("single", 100);
        checkOutput("single_tvalid_count", tv_cnt, 1);

        $display("[TB] reset in the middle of forwarding");
        tv_cnt = 0;
        applyStimulus(16, 1, 1);
        c = 0;
        while (tv_cnt < 3 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("midfwd_started", int'(tv_cnt >= 3), 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        fifo_q.delete();
        pend_v = 1'b0;
        checkOutput("midfwd_rst_rx_hold", int'(o_rx_hold), 0);
        checkOutput("midfwd_rst_rd_valid", int'(o_rd_valid), 0);
        checkOutput("midfwd_rst_txd_tvalid", int'(o_txd_tvalid), 0);
        checkOutput("midfwd_rst_fifo_invalid", int'(o_fifo_invalid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midfwd_after_rx_hold", int'(o_rx_hold), 0);
        checkOutput("midfwd_after_txd_tvalid", int'(o_txd_tvalid), 0);

        $display("[TB] 511-word frame, permit");
        tv_cnt = 0;
        applyStimulus(MAXW, 1, 1);
        waitDone("max511", 2000);
        checkOutput("max511_tvalid_count", tv_cnt, MAXW);
        checkOutput("max511_len_err", int'(o_len_err), 0);

        $display("[TB] 600-word frame, permit");
        tv_cnt = 0;
        applyStimulus(600, 1, 1);
        waitDone("over600", 2500);
        checkOutput("over600_len_err", int'(o_len_err), 1);
        checkOutput("over600_tvalid_count", tv_cnt, 0);
        fifo_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        fails++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
